// File: rtl/data_ram_rd_ctrl.sv
// ---------------------------------------------------------------------------
// data_ram_rd_ctrl
//   Per-bank read controller for one data RAM. Buffers incoming read
//   commands in a small FIFO, issues SRAM reads no closer together than
//   RD_GAP cycles, and returns the read data together with the command
//   payload that produced it. One credit is returned upstream for every
//   command issued to the SRAM.
//
//   Optional build macro:
//     DATA_RAM_RD_OUT_REG_EN  adds one output flop stage on rd_data_vld_o,
//                             rd_data_o and rd_data_pld_o (+1 cycle latency).
//
//   Ports:
//     clk                  clock
//     rst                  synchronous reset, active-high
//     rd_cmd_vld_i         read command valid (credit flow-controlled)
//     rd_cmd_pld_i         read command payload
//     rd_cmd_credit_rtn_o  one-cycle pulse per command issued
//     ram_cs_o             SRAM chip select (read)
//     ram_we_o             SRAM write enable, always 0
//     ram_addr_o           SRAM address, valid with ram_cs_o
//     ram_rdata_i          SRAM read data, valid RAM_LAT cycles after ram_cs_o
//     rd_data_vld_o        read data valid
//     rd_data_o            read data (0 when not valid)
//     rd_data_pld_o        payload of the originating command (0 when not valid)
//     ovf_err_o            sticky: a command arrived while the FIFO was full
// ---------------------------------------------------------------------------
package data_ram_rd_pkg;
    // Read command payload; only ram_addr[ADDR_W-1:0] reaches the SRAM,
    // the whole record travels with the read and comes back on rd_data_pld_o.
    typedef struct packed {
        logic [3:0]  src_id;
        logic [7:0]  tag;
        logic [15:0] ram_addr;
    } arb_out_req_t;
endpackage

module data_ram_rd_ctrl
    import data_ram_rd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,   // power of 2, >= 2
    parameter int RAM_LAT    = 2,   // >= 1
    parameter int RD_GAP     = 1,   // >= 1
    parameter int ADDR_W     = 10,  // <= 16
    parameter int DATA_W     = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_cmd_vld_i,
    input  arb_out_req_t      rd_cmd_pld_i,
    output logic              rd_cmd_credit_rtn_o,
    output logic              ram_cs_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              rd_data_vld_o,
    output logic [DATA_W-1:0] rd_data_o,
    output arb_out_req_t      rd_data_pld_o,
    output logic              ovf_err_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;
    localparam int GAP_W = (RD_GAP > 2) ? $clog2(RD_GAP - 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((RD_GAP > 1) ? (RD_GAP - 2) : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP
    } state_e;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    arb_out_req_t     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] occ_d;
    logic             full;
    logic             push;
    logic             pop;
    logic             nonempty_d;
    logic             ovf_err_q;
    arb_out_req_t     head;

    state_e           state_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             ram_cs_q;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                  (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign pop  = ram_cs_q;
    // A pop in the same cycle frees the slot, so push into a full FIFO is legal then.
    assign push = rd_cmd_vld_i && (!full || pop);

    assign wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    assign rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    assign occ_d      = wr_ptr_d - rd_ptr_d;
    // Occupancy after this cycle: a command pushed now can issue next cycle, never now.
    assign nonempty_d = (occ_d != '0);
    assign head       = fifo_mem[rd_ptr_q[IDX_W-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (rd_cmd_vld_i && full && !pop) begin
                ovf_err_q <= 1'b1;
            end
        end
    end

    // NOTE: the storage array is not reset; the pointers alone define which
    // entries are live, so clearing the data would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[IDX_W-1:0]] <= rd_cmd_pld_i;
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM: ram_cs_q is registered and true exactly in ST_ISSUE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            ram_cs_q  <= 1'b0;
        end else begin
            ram_cs_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (nonempty_d) begin
                        state_q  <= ST_ISSUE;
                        ram_cs_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (RD_GAP > 1) begin
                        state_q   <= ST_GAP;
                        gap_cnt_q <= GAP_LOAD;
                    end else if (nonempty_d) begin
                        state_q  <= ST_ISSUE;
                        ram_cs_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        if (nonempty_d) begin
                            state_q  <= ST_ISSUE;
                            ram_cs_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ram_cs_o            = ram_cs_q;
    assign ram_we_o            = 1'b0;
    assign ram_addr_o          = ram_cs_q ? head.ram_addr[ADDR_W-1:0] : '0;
    assign rd_cmd_credit_rtn_o = ram_cs_q;
    assign ovf_err_o           = ovf_err_q;

    // ------------------------------------------------------------------
    // Latency pipe: tracks each read so its payload meets ram_rdata_i.
    // Reset flushes it, so reads issued before reset never return.
    // ------------------------------------------------------------------
    logic [RAM_LAT-1:0] pipe_vld_q;
    arb_out_req_t       pipe_pld_q [RAM_LAT];
    logic               tail_vld;
    logic [DATA_W-1:0]  tail_data;
    arb_out_req_t       tail_pld;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < RAM_LAT; i++) begin
                pipe_pld_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= ram_cs_q;
            pipe_pld_q[0] <= ram_cs_q ? head : '0;
            for (int i = 1; i < RAM_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_pld_q[i] <= pipe_pld_q[i-1];
            end
        end
    end

    assign tail_vld  = pipe_vld_q[RAM_LAT-1];
    assign tail_data = tail_vld ? ram_rdata_i : '0;
    assign tail_pld  = tail_vld ? pipe_pld_q[RAM_LAT-1] : '0;

`ifdef DATA_RAM_RD_OUT_REG_EN
    logic              out_vld_q;
    logic [DATA_W-1:0] out_data_q;
    arb_out_req_t      out_pld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_pld_q  <= '0;
        end else begin
            out_vld_q  <= tail_vld;
            out_data_q <= tail_data;
            out_pld_q  <= tail_pld;
        end
    end

    assign rd_data_vld_o = out_vld_q;
    assign rd_data_o     = out_data_q;
    assign rd_data_pld_o = out_pld_q;
`else
    assign rd_data_vld_o = tail_vld;
    assign rd_data_o     = tail_data;
    assign rd_data_pld_o = tail_pld;
`endif

endmodule

// File: tb/tb_data_ram_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_ram_rd_ctrl
//   Drives three data_ram_rd_ctrl instances (RD_GAP = 1, 3, 4) from one
//   command stream. Every cycle each instance is compared with a queue-based
//   reference model; directed sequences and a vector table add fixed
//   expectations for latency, pacing, overflow and reset behaviour.
// ---------------------------------------------------------------------------
module tb_data_ram_rd_ctrl;
    import data_ram_rd_pkg::*;

    localparam int NI         = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int RAM_LAT    = 2;
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 256;
    localparam int MAXC       = 4000;
`ifdef DATA_RAM_RD_OUT_REG_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT = RAM_LAT + EXTRA;

    typedef struct packed {
        int           cyc;
        arb_out_req_t pld;
    } ret_t;

    typedef struct {
        bit          vld;
        logic [15:0] addr;
        bit [NI-1:0] cs;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_vld;
    arb_out_req_t      cmd_pld;
    logic [DATA_W-1:0] ram_rdata;

    logic              credit [NI];
    logic              cs     [NI];
    logic              we     [NI];
    logic [ADDR_W-1:0] addr   [NI];
    logic              rvld   [NI];
    logic [DATA_W-1:0] rdd    [NI];
    arb_out_req_t      rpld   [NI];
    logic              ovf    [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        data_ram_rd_ctrl #(
            .FIFO_DEPTH (FIFO_DEPTH),
            .RAM_LAT    (RAM_LAT),
            .RD_GAP     ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
            .ADDR_W     (ADDR_W),
            .DATA_W     (DATA_W)
        ) u_dut (
            .clk                 (clk),
            .rst                 (rst),
            .rd_cmd_vld_i        (cmd_vld),
            .rd_cmd_pld_i        (cmd_pld),
            .rd_cmd_credit_rtn_o (credit[g]),
            .ram_cs_o            (cs[g]),
            .ram_we_o            (we[g]),
            .ram_addr_o          (addr[g]),
            .ram_rdata_i         (ram_rdata),
            .rd_data_vld_o       (rvld[g]),
            .rd_data_o           (rdd[g]),
            .rd_data_pld_o       (rpld[g]),
            .ovf_err_o           (ovf[g])
        );
    end

    always #5 clk = ~clk;

    // Reference model state
    arb_out_req_t      mq [NI][$];
    ret_t              rq [NI][$];
    int                last_iss [NI];
    bit                movf [NI];
    logic [DATA_W-1:0] rhist [MAXC];

    // Snapshot of DUT outputs from the most recent cycle
    logic              s_cs [NI], s_cr [NI], s_rv [NI], s_ovf [NI];
    logic [ADDR_W-1:0] s_addr [NI];
    arb_out_req_t      s_rp [NI];

    int cyc;
    int n_chk;
    int n_fail;

    function automatic int gap_of(int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    endfunction

    function automatic arb_out_req_t mk(logic [15:0] a);
        arb_out_req_t p;
        p.src_id   = 4'($urandom());
        p.tag      = 8'($urandom());
        p.ram_addr = a;
        return p;
    endfunction

    task automatic check(input string name, input int g,
                         input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", name, g, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < NI; g++) begin
            mq[g].delete();
            rq[g].delete();
            last_iss[g] = -1000;
            movf[g]     = 1'b0;
        end
    endtask

    // One clock cycle: apply inputs, compare every instance to the model at
    // mid-cycle, advance the model, then move past the next rising edge.
    task automatic tick(input bit v, input arb_out_req_t p, input bit r);
        bit                iss;
        bit                rv;
        logic [ADDR_W-1:0] e_addr;
        arb_out_req_t      e_pld;
        logic [DATA_W-1:0] e_data;
        ret_t              e;
        cmd_vld = v;
        cmd_pld = p;
        rst     = r;
        for (int k = 0; k < DATA_W / 32; k++) begin
            ram_rdata[k*32 +: 32] = $urandom();
        end
        rhist[cyc] = ram_rdata;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            s_cs[g]   = cs[g];
            s_cr[g]   = credit[g];
            s_rv[g]   = rvld[g];
            s_ovf[g]  = ovf[g];
            s_addr[g] = addr[g];
            s_rp[g]   = rpld[g];

            iss    = (mq[g].size() > 0) && (cyc - last_iss[g] >= gap_of(g));
            e_addr = iss ? mq[g][0].ram_addr[ADDR_W-1:0] : '0;
            rv     = (rq[g].size() > 0) && (rq[g][0].cyc == cyc);
            e_pld  = rv ? rq[g][0].pld : '0;
            e_data = rv ? rhist[cyc-EXTRA] : '0;

            check("ram_cs", g, DATA_W'(cs[g]), DATA_W'(iss));
            check("credit", g, DATA_W'(credit[g]), DATA_W'(iss));
            if (iss) check("ram_addr", g, DATA_W'(addr[g]), DATA_W'(e_addr));
            check("ram_we", g, DATA_W'(we[g]), '0);
            check("rd_vld", g, DATA_W'(rvld[g]), DATA_W'(rv));
            check("rd_data", g, rdd[g], e_data);
            check("rd_pld", g, DATA_W'(rpld[g]), DATA_W'(e_pld));
            check("ovf_err", g, DATA_W'(ovf[g]), DATA_W'(movf[g]));

            if (r) begin
                mq[g].delete();
                rq[g].delete();
                last_iss[g] = -1000;
                movf[g]     = 1'b0;
            end else begin
                if (rv) void'(rq[g].pop_front());
                if (iss) begin
                    e.cyc = cyc + LAT;
                    e.pld = mq[g].pop_front();
                    rq[g].push_back(e);
                    last_iss[g] = cyc;
                end
                if (v) begin
                    if (mq[g].size() < FIFO_DEPTH) mq[g].push_back(p);
                    else movf[g] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, '0, 1'b0);
    endtask

    // Single command at 0x1A5 on the RD_GAP=1 instance: ram_cs and credit one
    // cycle after the push, rd_data_vld LAT cycles after ram_cs.
    task automatic single_cmd_seq();
        arb_out_req_t p1;
        p1 = mk(16'h01A5);
        tick(1'b1, p1, 1'b0);
        check("t1_cs_at_push", 0, DATA_W'(s_cs[0]), '0);
        tick(1'b0, '0, 1'b0);
        check("t1_cs", 0, DATA_W'(s_cs[0]), DATA_W'(1'b1));
        check("t1_addr", 0, DATA_W'(s_addr[0]), DATA_W'(10'h1A5));
        check("t1_credit", 0, DATA_W'(s_cr[0]), DATA_W'(1'b1));
        for (int k = 2; k <= LAT + 2; k++) begin
            tick(1'b0, '0, 1'b0);
            check("t1_credit_once", 0, DATA_W'(s_cr[0]), '0);
            check("t1_rd_vld", 0, DATA_W'(s_rv[0]), DATA_W'(k == LAT + 1));
            if (k == LAT + 1) check("t1_rd_pld", 0, DATA_W'(s_rp[0]), DATA_W'(p1));
        end
    endtask

    initial begin
        vec_t tbl [14];
        int   n_iss [NI];
        int   n_ret [NI];
        bit   e_rv;

        tbl[0]  = '{1'b1, 16'h0010, 3'b000};
        tbl[1]  = '{1'b1, 16'h0020, 3'b111};
        tbl[2]  = '{1'b1, 16'h0030, 3'b001};
        tbl[3]  = '{1'b1, 16'h0040, 3'b001};
        tbl[4]  = '{1'b0, 16'h0000, 3'b011};
        tbl[5]  = '{1'b0, 16'h0000, 3'b100};
        tbl[6]  = '{1'b0, 16'h0000, 3'b000};
        tbl[7]  = '{1'b0, 16'h0000, 3'b010};
        tbl[8]  = '{1'b0, 16'h0000, 3'b000};
        tbl[9]  = '{1'b0, 16'h0000, 3'b100};
        tbl[10] = '{1'b0, 16'h0000, 3'b010};
        tbl[11] = '{1'b0, 16'h0000, 3'b000};
        tbl[12] = '{1'b0, 16'h0000, 3'b000};
        tbl[13] = '{1'b0, 16'h0000, 3'b100};

        cyc       = 0;
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        cmd_vld   = 1'b0;
        cmd_pld   = '0;
        ram_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();

        // Reset state: all outputs 0 on the first cycle out of reset.
        tick(1'b0, '0, 1'b0);
        for (int g = 0; g < NI; g++) begin
            check("rst_cs", g, DATA_W'(s_cs[g]), '0);
            check("rst_rvld", g, DATA_W'(s_rv[g]), '0);
            check("rst_ovf", g, DATA_W'(s_ovf[g]), '0);
        end

        // Single command pushed at cycle 10.
        idle(9);
        single_cmd_seq();
        idle(8);

        // Four back-to-back commands; expected ram_cs per instance from the table.
        for (int g = 0; g < NI; g++) begin
            n_iss[g] = 0;
            n_ret[g] = 0;
        end
        for (int k = 0; k < 14; k++) begin
            tick(tbl[k].vld, mk(tbl[k].addr), 1'b0);
            for (int g = 0; g < NI; g++) begin
                check("tbl_cs", g, DATA_W'(s_cs[g]), DATA_W'(tbl[k].cs[g]));
                check("tbl_credit", g, DATA_W'(s_cr[g]), DATA_W'(tbl[k].cs[g]));
                if (tbl[k].cs[g]) begin
                    check("tbl_addr", g, DATA_W'(s_addr[g]), DATA_W'(tbl[n_iss[g]].addr[ADDR_W-1:0]));
                    n_iss[g]++;
                end
                e_rv = (k >= LAT) ? tbl[k-LAT].cs[g] : 1'b0;
                check("tbl_rvld", g, DATA_W'(s_rv[g]), DATA_W'(e_rv));
                if (e_rv) begin
                    check("tbl_order", g, DATA_W'(s_rp[g].ram_addr), DATA_W'(tbl[n_ret[g]].addr));
                    n_ret[g]++;
                end
            end
        end
        idle(6);
        for (int g = 0; g < NI; g++) check("b2b_no_ovf", g, DATA_W'(s_ovf[g]), '0);

        // Overflow: seven commands back-to-back. RD_GAP=4 and RD_GAP=3 fill up
        // and drop the seventh; the sixth hits a full FIFO in a pop cycle on RD_GAP=4.
        for (int k = 0; k < 7; k++) begin
            tick(1'b1, mk(16'(16'h100 + k)), 1'b0);
            if (k == 6) check("ovf_full_pop", 2, DATA_W'(s_ovf[2]), '0);
        end
        tick(1'b0, '0, 1'b0);
        check("ovf_g1", 0, DATA_W'(s_ovf[0]), '0);
        check("ovf_g3", 1, DATA_W'(s_ovf[1]), DATA_W'(1'b1));
        check("ovf_g4", 2, DATA_W'(s_ovf[2]), DATA_W'(1'b1));
        idle(40);
        check("ovf_sticky", 2, DATA_W'(s_ovf[2]), DATA_W'(1'b1));

        // Reset one cycle after ram_cs: the in-flight read never returns, the
        // FIFO is emptied and ovf_err clears.
        tick(1'b1, mk(16'h0155), 1'b0);
        tick(1'b1, mk(16'h0266), 1'b0);
        check("rst_seq_cs", 0, DATA_W'(s_cs[0]), DATA_W'(1'b1));
        tick(1'b0, '0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, '0, 1'b0);
            for (int g = 0; g < NI; g++) begin
                check("rst_flush_rvld", g, DATA_W'(s_rv[g]), '0);
                check("rst_fifo_empty", g, DATA_W'(s_cs[g]), '0);
                check("rst_ovf_clr", g, DATA_W'(s_ovf[g]), '0);
            end
        end
        single_cmd_seq();
        idle(6);

        // Random traffic with occasional resets, checked by the model each cycle.
        for (int k = 0; k < 1500; k++) begin
            tick($urandom_range(0, 99) < 60, mk(16'($urandom())), $urandom_range(0, 299) == 0);
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
